// File: rtl/core_insn_loader_pkg.sv
// Shared constants and state encoding for the per-core instruction loader.
// The task scheduler uses the same frame geometry constants.
package core_insn_loader_pkg;

  localparam int unsigned NUM_OF_CORES_DEF   = 4;
  localparam int unsigned INSN_LOAD_TIME_DEF = 4;
  localparam int unsigned CNT_W_DEF          = 2;
  localparam int unsigned PART_W_DEF         = 64;
  localparam int unsigned REG_W_DEF          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/core_insn_loader_check.sv
// Frame protocol checker: tracks the expected part counter and decodes
// protocol errors into an abort strobe and a sticky error flag.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   state           current loader state (core_insn_loader_pkg::state_t encoding)
//   start_sel       this core's Start bit
//   load_cnt        scheduler part counter
//   abort_c         combinational: current LOAD cycle is malformed, abort frame
//   load_err        sticky protocol error, cleared only by reset
module core_insn_loader_check
  import core_insn_loader_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       state,
  input  logic             start_sel,
  input  logic [CNT_W-1:0] load_cnt,
  output logic             abort_c,
  output logic             load_err
);

  logic [CNT_W-1:0] exp_cnt;
  logic             idle_bad_c;
  logic             run_bad_c;

  // Error decode per state
  always_comb begin
    abort_c    = 1'b0;
    idle_bad_c = 1'b0;
    run_bad_c  = 1'b0;
    case (state)
      ST_IDLE: idle_bad_c = start_sel && (load_cnt != '0);
      ST_LOAD: abort_c    = !start_sel || (load_cnt != exp_cnt);
      ST_RUN:  run_bad_c  = start_sel;
      default: ;
    endcase
  end

  // Expected counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_cnt  <= '0;
      load_err <= 1'b0;
    end else begin
      if (abort_c || idle_bad_c || run_bad_c) load_err <= 1'b1;
      if (state == ST_IDLE && start_sel && load_cnt == '0) begin
        exp_cnt <= CNT_W'(1);
      end else if (state == ST_LOAD && !abort_c) begin
        exp_cnt <= exp_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/core_insn_loader.sv
// Per-core receive stage behind the task scheduler: writes the streamed
// instruction-frame parts into the core's instruction memory, latches the
// optional R0 initial value, launches the core and holds ready low until
// the core halts.
// Optional feature macro: CORE_INSN_LOADER_CHECK_EN enables frame protocol
// checking (abort on malformed frames, sticky load_err). Undefined: load_err
// is tied 0 and the part counter is trusted.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           scheduler Start bus, bit CORE_ID used
//   load_cnt        scheduler part counter
//   insn_data       scheduler part data
//   init_r0_vect    R0-init enables, bit CORE_ID used
//   init_r0         R0 values, slice CORE_ID used
//   core_halt       single-cycle pulse, core finished
//   ready           high while idle or loading
//   imem_we/waddr/wdata  instruction-memory write port (combinational)
//   core_go         one-cycle launch pulse
//   r0_we/r0_wdata  one-cycle R0 write, coincident with core_go
//   load_err        sticky protocol error
module core_insn_loader
  import core_insn_loader_pkg::*;
#(
  parameter int unsigned CORE_ID        = 0,
  parameter int unsigned NUM_OF_CORES   = NUM_OF_CORES_DEF,
  parameter int unsigned INSN_LOAD_TIME = INSN_LOAD_TIME_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned PART_W         = PART_W_DEF,
  parameter int unsigned REG_W          = REG_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_OF_CORES-1:0]   start,
  input  logic [CNT_W-1:0]          load_cnt,
  input  logic [PART_W-1:0]         insn_data,
  input  logic [NUM_OF_CORES-1:0]   init_r0_vect,
  input  logic [NUM_OF_CORES*REG_W-1:0] init_r0,
  input  logic                      core_halt,
  output logic                      ready,
  output logic                      imem_we,
  output logic [CNT_W-1:0]          imem_waddr,
  output logic [PART_W-1:0]         imem_wdata,
  output logic                      core_go,
  output logic                      r0_we,
  output logic [REG_W-1:0]          r0_wdata,
  output logic                      load_err
);

  state_t           state;
  logic             start_sel;
  logic             r0_en_sel;
  logic [REG_W-1:0] r0_sel;
  logic             r0_en_q;
  logic [REG_W-1:0] r0_val_q;
  logic             first_c;
  logic             wr_c;
  logic             last_c;
  logic             launch_c;
  logic             abort_c;
  logic             unused_bits;

  assign start_sel = start[CORE_ID];
  assign r0_en_sel = init_r0_vect[CORE_ID];
  assign r0_sel    = init_r0[CORE_ID*REG_W +: REG_W];

  // Other cores' lanes are not used by this instance
  assign unused_bits = ^{start, init_r0_vect, init_r0};

`ifdef CORE_INSN_LOADER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;

  core_insn_loader_check #(
    .CNT_W (CNT_W)
  ) u_check (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .start_sel (start_sel),
    .load_cnt  (load_cnt),
    .abort_c   (abort_c),
    .load_err  (load_err)
  );
`else
  localparam bit CHECK_EN = 1'b0;

  assign abort_c  = 1'b0;
  assign load_err = 1'b0;
`endif

  // Write acceptance and launch decode
  always_comb begin
    first_c  = (state == ST_IDLE) && start_sel && (load_cnt == '0);
    wr_c     = 1'b0;
    case (state)
      ST_IDLE: wr_c = start_sel && ((load_cnt == '0) || !CHECK_EN);
      ST_LOAD: wr_c = start_sel && !abort_c;
      default: wr_c = 1'b0;
    endcase
    last_c   = (load_cnt == CNT_W'(INSN_LOAD_TIME - 1));
    // A single-part frame launches straight from IDLE
    launch_c = last_c && (first_c || ((state == ST_LOAD) && wr_c));
  end

  assign imem_we    = wr_c && !reset;
  assign imem_waddr = load_cnt;
  assign imem_wdata = insn_data;

  // Loader FSM with registered launch outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      core_go  <= 1'b0;
      r0_we    <= 1'b0;
      r0_wdata <= '0;
      r0_en_q  <= 1'b0;
      r0_val_q <= '0;
    end else begin
      core_go <= 1'b0;
      r0_we   <= 1'b0;
      if (first_c) begin
        r0_en_q  <= r0_en_sel;
        r0_val_q <= r0_sel;
      end
      if (launch_c) begin
        state    <= ST_RUN;
        ready    <= 1'b0;
        core_go  <= 1'b1;
        // Capture and launch coincide when the frame is one part long
        r0_we    <= first_c ? r0_en_sel : r0_en_q;
        r0_wdata <= first_c ? r0_sel : r0_val_q;
      end else begin
        case (state)
          ST_IDLE: if (first_c) state <= ST_LOAD;
          ST_LOAD: if (abort_c) state <= ST_IDLE;
          ST_RUN: begin
            if (core_halt) begin
              state <= ST_IDLE;
              ready <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_insn_loader.sv
// Self-checking bench for core_insn_loader (CORE_ID=1, four-part frames):
// directed scenarios followed by randomized traffic, all compared against a
// frame-level reference model.
module tb_core_insn_loader;

  localparam int unsigned NC = 4;
  localparam int unsigned T  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned PW = 64;
  localparam int unsigned RW = 8;
  localparam int unsigned ID = 1;

`ifdef CORE_INSN_LOADER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NC-1:0]     start;
  logic [CW-1:0]     load_cnt;
  logic [PW-1:0]     insn_data;
  logic [NC-1:0]     init_r0_vect;
  logic [NC*RW-1:0]  init_r0;
  logic              core_halt;
  logic              ready;
  logic              imem_we;
  logic [CW-1:0]     imem_waddr;
  logic [PW-1:0]     imem_wdata;
  logic              core_go;
  logic              r0_we;
  logic [RW-1:0]     r0_wdata;
  logic              load_err;

  core_insn_loader #(
    .CORE_ID        (ID),
    .NUM_OF_CORES   (NC),
    .INSN_LOAD_TIME (T),
    .CNT_W          (CW),
    .PART_W         (PW),
    .REG_W          (RW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_cnt     (load_cnt),
    .insn_data    (insn_data),
    .init_r0_vect (init_r0_vect),
    .init_r0      (init_r0),
    .core_halt    (core_halt),
    .ready        (ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_go      (core_go),
    .r0_we        (r0_we),
    .r0_wdata     (r0_wdata),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: running flag, parts taken in the current frame, R0 capture
  bit         m_known  = 1'b0;
  bit         m_run    = 1'b0;
  int         m_parts  = 0;
  bit         m_r0en   = 1'b0;
  logic [7:0] m_r0val  = '0;
  bit         e_ready  = 1'b1;
  bit         e_go     = 1'b0;
  bit         e_r0we   = 1'b0;
  logic [7:0] e_r0data = '0;
  bit         e_err    = 1'b0;
  int         n_go     = 0;

  task automatic step(input bit rst, input logic [3:0] st, input logic [1:0] cnt,
                      input logic [63:0] data, input logic [3:0] vect,
                      input logic [31:0] r0, input bit halt);
    bit         sel;
    bit         we_e;
    bit         launch;
    logic [7:0] r0s;
    @(negedge clk);
    reset        = rst;
    start        = st;
    load_cnt     = cnt;
    insn_data    = data;
    init_r0_vect = vect;
    init_r0      = r0;
    core_halt    = halt;
    #1;
    sel  = st[ID];
    r0s  = r0[ID*RW +: RW];
    if (m_parts == 0)
      we_e = !rst && !m_run && sel && (!CHK || cnt == 2'd0);
    else
      we_e = !rst && !m_run && sel && (!CHK || int'(cnt) == m_parts);
    chk("imem_we", 64'(imem_we), 64'(we_e));
    if (we_e) begin
      chk("imem_waddr", 64'(imem_waddr), 64'(cnt));
      chk("imem_wdata", imem_wdata, data);
    end
    if (m_known) begin
      chk("ready", 64'(ready), 64'(e_ready));
      chk("core_go", 64'(core_go), 64'(e_go));
      chk("r0_we", 64'(r0_we), 64'(e_r0we));
      chk("r0_wdata", 64'(r0_wdata), 64'(e_r0data));
      chk("load_err", 64'(load_err), 64'(e_err));
    end
    @(posedge clk);
    e_go   = 1'b0;
    e_r0we = 1'b0;
    launch = 1'b0;
    if (rst) begin
      m_known  = 1'b1;
      m_run    = 1'b0;
      m_parts  = 0;
      m_r0en   = 1'b0;
      m_r0val  = '0;
      e_ready  = 1'b1;
      e_r0data = '0;
      e_err    = 1'b0;
    end else if (m_run) begin
      if (CHK && sel) e_err = 1'b1;
      if (halt) begin
        m_run   = 1'b0;
        e_ready = 1'b1;
      end
    end else if (m_parts == 0) begin
      if (sel && cnt == 2'd0) begin
        m_r0en  = vect[ID];
        m_r0val = r0s;
        if (T == 1) launch = 1'b1;
        else m_parts = 1;
      end else if (sel && CHK) begin
        e_err = 1'b1;
      end
    end else begin
      if (CHK && (!sel || int'(cnt) != m_parts)) begin
        e_err   = 1'b1;
        m_parts = 0;
      end else if (sel) begin
        if (int'(cnt) == T - 1) launch = 1'b1;
        else m_parts++;
      end
    end
    if (launch) begin
      m_run    = 1'b1;
      m_parts  = 0;
      e_go     = 1'b1;
      e_r0we   = m_r0en;
      e_r0data = m_r0val;
      e_ready  = 1'b0;
      n_go++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 2'd0, 64'd0, 4'b0000, 32'd0, 1'b0);
  endtask

  task automatic frame(input logic [3:0] vect, input logic [31:0] r0, input logic [63:0] base);
    for (int k = 0; k < int'(T); k++)
      step(1'b0, 4'b0010, 2'(k), base + 64'(k), vect, r0, 1'b0);
  endtask

  task automatic halt_pulse();
    step(1'b0, 4'b0000, 2'd0, 64'd0, 4'b0000, 32'd0, 1'b1);
  endtask

  initial begin
    int         k;
    int         go_before;
    bit         rst;
    bit         hlt;
    logic [3:0] st;
    logic [1:0] cnt;
    logic [3:0] vect;

    step(1'b1, 4'b0000, 2'd0, 64'd0, 4'b0000, 32'd0, 1'b0);
    step(1'b1, 4'b0000, 2'd0, 64'd0, 4'b0000, 32'd0, 1'b0);
    idle(2);

    // Clean load with R0 init, run, halt
    frame(4'b0010, 32'h0000_5A00, 64'hA0);
    idle(6);
    halt_pulse();
    idle(1);

    // R0 init disabled; then back-to-back frame right after ready rises
    frame(4'b0000, 32'h0000_3300, 64'hB0);
    idle(3);
    halt_pulse();
    go_before = n_go;
    frame(4'b1111, 32'h1234_5678, 64'hC0);
    chk("b2b_launch", 64'(n_go - go_before), 64'd1);
    halt_pulse();

    // Halt coincident with core_go
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 2'(i), 64'hD0, 4'b0010, 32'h0000_7700, 1'b0);
    step(1'b0, 4'b0010, 2'd3, 64'hD3, 4'b0000, 32'd0, 1'b0);
    halt_pulse();
    idle(2);

    // Other core's start only
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, 2'(i), 64'hE0, 4'b0100, 32'hFFFF_FFFF, 1'b0);

    // Malformed counter sequence 0,1,3 then a further cnt=3 part
    step(1'b0, 4'b0010, 2'd0, 64'hF0, 4'b0010, 32'h0000_1100, 1'b0);
    step(1'b0, 4'b0010, 2'd1, 64'hF1, 4'b0010, 32'h0000_1100, 1'b0);
    step(1'b0, 4'b0010, 2'd3, 64'hF3, 4'b0010, 32'h0000_1100, 1'b0);
    idle(2);
    step(1'b0, 4'b0010, 2'd3, 64'hF4, 4'b0000, 32'd0, 1'b0);
    idle(2);
    halt_pulse();
    idle(1);

    // Reset mid-load, then a fresh frame
    step(1'b0, 4'b0010, 2'd0, 64'h10, 4'b0010, 32'h0000_2200, 1'b0);
    step(1'b0, 4'b0010, 2'd1, 64'h11, 4'b0010, 32'h0000_2200, 1'b0);
    step(1'b1, 4'b0000, 2'd0, 64'd0, 4'b0000, 32'd0, 1'b0);
    go_before = n_go;
    frame(4'b0010, 32'h0000_6600, 64'h20);
    chk("post_reset_launch", 64'(n_go - go_before), 64'd1);
    idle(2);
    halt_pulse();

    // Randomized traffic
    k = 0;
    repeat (3000) begin
      rst  = ($urandom_range(0, 199) == 0);
      st   = 4'($urandom) & ~4'b0010;
      cnt  = 2'($urandom);
      vect = 4'($urandom);
      hlt  = 1'b0;
      if (m_run) begin
        hlt = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 19) == 0) st[ID] = 1'b1;
      end else begin
        hlt = ($urandom_range(0, 9) == 0);
        if (m_parts == 0 && $urandom_range(0, 1) == 0) k = 0;
        if ($urandom_range(0, 7) != 0) begin
          st[ID] = 1'b1;
          cnt    = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'(k);
          k      = (k + 1) % int'(T);
        end
      end
      step(rst, st, cnt, {$urandom, $urandom}, vect, $urandom, hlt);
      if (rst) k = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_insn_loader.md
# core_insn_loader

Per-core receive stage directly downstream of the task scheduler. Captures the instruction-frame parts the scheduler streams to a core (start strobe, part counter, part data), writes them into the core's instruction memory, and latches the optional R0 initial value. It then launches the core and holds the core's Ready line low until the core halts. One instance sits in front of each core.

## Interface
- CORE_ID, 0: index of this core in the scheduler's Start, Init_R0_Vect and Init_R0 buses.
- NUM_OF_CORES, 4: width of the Start and Init_R0_Vect buses.
- INSN_LOAD_TIME, 4: parts per frame; counter runs 0..INSN_LOAD_TIME-1.
- CNT_W, 2: part-counter width, $clog2(INSN_LOAD_TIME).
- PART_W, 64: width of one part on the instruction bus.
- REG_W, 8: R0 width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  NUM_OF_CORES  scheduler Start bus; bit CORE_ID is used.
- load_cnt  in  CNT_W  scheduler part counter.
- insn_data  in  PART_W  scheduler part data.
- init_r0_vect  in  NUM_OF_CORES  R0-init enables; bit CORE_ID is used.
- init_r0  in  NUM_OF_CORES*REG_W  R0 values; slice CORE_ID is used.
- core_halt  in  1  core finished its program; single-cycle pulse.
- ready  out  1  to scheduler; high = idle or loading.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  CNT_W  part slot address.
- imem_wdata  out  PART_W  part data.
- core_go  out  1  one-cycle launch pulse; the core resets its PC to 0.
- r0_we  out  1  one-cycle R0 write, coincident with core_go.
- r0_wdata  out  REG_W  R0 value.
- load_err  out  1  sticky protocol error (see Configuration).

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - ready=1.
  - start[CORE_ID]=1 with load_cnt=0 → write part 0 → LOAD, exp_cnt=1.
  - Capture init_r0_vect[CORE_ID] and the init_r0 slice in the same cycle.
- LOAD:
  - ready=1.
  - Each cycle with start[CORE_ID]=1 writes insn_data to slot load_cnt.
  - A write with load_cnt=INSN_LOAD_TIME-1 → RUN.
- Write port: imem_we = start[CORE_ID] in IDLE/LOAD, combinational; imem_waddr = load_cnt; imem_wdata = insn_data.
- RUN entry:
  - core_go=1 for one cycle.
  - r0_we = captured enable; r0_wdata = captured value.
  - ready=0 from the entry cycle on.
- RUN:
  - core_halt → IDLE, ready=1 next cycle.
  - start[CORE_ID] in RUN is ignored; no write occurs.
- INSN_LOAD_TIME=1: the IDLE cycle with load_cnt=0 is also the last part → RUN directly.
- Reset in any state → IDLE. Reset values: ready=1, core_go=0, r0_we=0, r0_wdata=0, load_err=0, imem_we=0.

## Timing
- Last part accepted in cycle n:
  - core_go, r0_we high in cycle n+1 only.
  - ready low from n+1.
  - The scheduler's insn_finish check is therefore correct in n+1.
- core_halt in cycle m → ready=1 in m+1; a new load may begin in m+1.
- core_halt in the same cycle as core_go is legal → RUN for one cycle, ready=1 at n+2.
- core_halt outside RUN is ignored.
- Load throughput: one part per cycle; no backpressure.

## Configuration
- CORE_INSN_LOADER_CHECK_EN defined:
  - In LOAD, start[CORE_ID]=0 or load_cnt≠exp_cnt sets load_err, suppresses the write, aborts to IDLE, and suppresses core_go.
  - start in RUN sets load_err.
  - IDLE start with load_cnt≠0 sets load_err and stays IDLE.
  - load_err clears only on reset.
- Undefined:
  - load_err tied 0.
  - load_cnt is trusted; an LOAD cycle without start simply waits (no abort).

## Structure
- Shared defines include: INSN_LOAD_TIME, part width, REG_W, state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2). The scheduler uses the same constants.
- One sub-module: core_insn_loader_check (exp_cnt tracking and error decode), instantiated only under CORE_INSN_LOADER_CHECK_EN.

## Test plan
- Clean load, T=4, CORE_ID=1: start=4'b0010, cnt 0..3, data A0..A3 → 4 writes to slots 0..3, core_go at cycle 5, ready 0 from cycle 5, core_halt at 12 → ready=1 at 13.
- R0 init: init_r0_vect=4'b0010, init_r0 slice1=8'h5A at the cnt=0 cycle → r0_we=1, r0_wdata=8'h5A with core_go. With vect bit 0 → r0_we stays 0.
- Back-to-back frames: second load starts the cycle after ready rises → second core_go exactly 5 cycles later; slot contents overwritten.
- Other-core start=4'b0100 → no imem_we, no core_go, ready stays 1.
- CHECK_EN: cnt sequence 0,1,3 → load_err=1, no write at slot 3, state IDLE, no core_go. Without CHECK_EN the same stimulus → write at slot 3 and no core_go until a cnt=3 write completes the frame.
- Reset asserted mid-LOAD (after part 1) → next cycle ready=1, load_err=0; a fresh load completes normally.
